fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Reader-side adapter for the team's synchronous FIFOs: drives the FIFO read strobe and turns the FIFO read port into a valid/ready stream.
- The FIFO read port has 1-cycle registered read data: `rd` is valid on the cycle after `re` is sampled high.
- A small internal skid queue absorbs the read latency. This gives one word per cycle sustained throughput with no combinational path from `out_ready` to `re`.
- Sits between any FIFO instance and downstream stream consumers.

Parameters:
- `W`, 4, data width in bits (matches the FIFO `W`)
- `D`, 3, skid-queue depth in words; legal range is 3 or more. 3 is the minimum for full throughput without a ready-to-re path.
- `CW`, 16, width of the delivered-word counter

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `empty`  in  1  FIFO empty flag, registered in the FIFO
- `re`  out  1  FIFO read enable, one word per high cycle
- `rd`  in  W  FIFO read data, valid the cycle after `re` was high
- `out_valid`  out  1  stream data valid
- `out_ready`  in  1  stream consumer ready
- `out_data`  out  W  stream data; head of the skid queue
- `count`  out  CW  number of words delivered (`out_valid && out_ready`), wraps modulo 2^CW

Behaviour:
- Reset (`rst` high at a clock edge):
  - occupancy `occ` = 0; in-flight flag `infl` = 0; `count` = 0; `out_valid` = 0; `out_data` = 0.
  - `re` = 0 in every cycle where `rst` is high.
  - Read data returning on the cycle after reset, from a read issued before reset, is discarded.
- Read issue:
  - `re = !rst && !empty && (occ + infl < D)`, evaluated combinationally.
  - `re` depends only on registered state, `empty` and `rst`; never on `out_ready`.
  - `infl <= re` each cycle.
- Capture: if `infl` is 1, `rd` is written at the tail of the queue that cycle.
  - The issue rule guarantees the queue is never full when data arrives; overflow is impossible by construction.
- Output:
  - `out_valid = (occ != 0)`, registered state only.
  - `out_data` = head entry; held stable while `out_valid && !out_ready`.
- Pop: when `out_valid && out_ready`, the head advances and `count` increments by 1, wrapping from 2^CW-1 to 0.
- Simultaneous capture and pop: `occ` is unchanged; the captured word goes behind all existing words. Strict FIFO order is always kept.
- Capture into an empty queue: the word appears on `out_data` with `out_valid` = 1 on the next cycle. It is never bypassed combinationally.
- Latency, FIFO non-empty to first `out_valid`: `re` in cycle t, capture at edge t+1, `out_valid` from cycle t+2.
- Throughput: continuous `out_ready` with the FIFO never empty gives 1 word per cycle once steady state is reached (`occ` = 1, `infl` = 1).
- Backpressure: with `out_ready` = 0, reads continue until `occ + infl = D`, then `re` stays 0. After `out_ready` returns, the first pop occurs the same cycle; `re` resumes the following cycle.
- `empty` going high mid-stream: `re` drops immediately; the queue drains normally.
- `empty` is trusted as accurate. Reading an empty FIFO never occurs, because `re` is gated by `empty`.
- Queue implementation: circular buffer with wrapping head/tail pointers plus `occ` counter (0..D). Pointer wrap at D must work for non-power-of-two D.

Test Plan:
- Reset then stream:
  - Stimulus: `rst` high 10 cycles; FIFO preloaded with 0,1,2,3; `out_ready` = 1.
  - Required: `re` high 4 consecutive cycles; `out_data` = 0,1,2,3 on 4 consecutive `out_valid` cycles, first `out_valid` 2 cycles after first `re`; `count` = 4; `re` = 0 once `empty` = 1.
- Backpressure, D=3:
  - Stimulus: FIFO holds 8 words; `out_ready` = 0.
  - Required: exactly 3 `re` pulses; `occ` = 3; `out_valid` = 1 with `out_data` = first word, held stable.
  - Then `out_ready` = 1: all 8 words in order; no gaps after the first pop cycle; `count` = 8.
- Throughput:
  - Stimulus: FIFO refilled every cycle (never empty); `out_ready` = 1 for 20 cycles.
  - Required: 18 or more words delivered; `out_valid` continuously high after startup.
- Random `out_ready` toggling with 16 words 0..F:
  - Required: output sequence exactly 0..F; `out_data` never changes while `out_valid && !out_ready`; no word lost or duplicated.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle while `occ` = 2 and `infl` = 1.
  - Required: next cycle `out_valid` = 0, `count` = 0; the returning in-flight word is not captured; `re` = 0 during reset.
- Counter wrap:
  - Stimulus: CW=4; deliver 17 words.
  - Required: `count` = 1.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus the outgoing valid/ready stream, seen from the adapter (master)
// and from the FIFO/consumer environment (slave).
interface fifo_rd_stream_if #(
  parameter int W = 4
);
  logic         empty;
  logic         re;
  logic [W-1:0] rd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    input  empty, rd, out_ready,
    output re, out_valid, out_data
  );

  modport slave (
    output empty, rd, out_ready,
    input  re, out_valid, out_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Reader-side adapter: issues FIFO reads and re-times the 1-cycle read data through a
// small circular skid queue so the stream runs at one word per cycle without ready->re.
module fifo_rd_stream #(
  parameter int W  = 4,
  parameter int D  = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  fifo_rd_stream_if.master bus,
  output logic [CW-1:0] count
);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int OW = $clog2(D + 1);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          infl_q, infl_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW:0]   pending;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  // Words already held plus the one in flight must fit, so capture never overflows.
  assign pending       = {1'b0, occ_q} + (OW + 1)'(infl_q);
  assign bus.re        = !rst && !bus.empty && (pending < (OW + 1)'(D));
  assign bus.out_valid = (occ_q != '0);
  assign bus.out_data  = mem_q[head_q];
  assign pop           = bus.out_valid && bus.out_ready;
  assign count         = count_q;

  always_comb begin
    infl_d  = bus.re;
    head_d  = pop ? ptr_inc(head_q) : head_q;
    tail_d  = infl_q ? ptr_inc(tail_q) : tail_q;
    occ_d   = occ_q + OW'(infl_q) - OW'(pop);
    count_d = pop ? count_q + CW'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      infl_q  <= 1'b0;
      count_q <= '0;
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      infl_q  <= infl_d;
      count_q <= count_d;
      if (infl_q) mem_q[tail_q] <= bus.rd;
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO with registered empty and
// 1-cycle read data, cycle tables for streaming/backpressure, plus corner sequences.
module tb_fifo_rd_stream;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] fq [$];

  fifo_rd_stream_if #(.W(4)) bus ();

  fifo_rd_stream #(.W(4), .D(3), .CW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO read side: data one cycle after re, empty registered.
  always @(posedge clk) begin
    if (bus.re) begin
      checks++;
      if (fq.size() == 0) begin
        failures++;
        $display("FAIL fifo_underflow actual=re_on_empty required=no_read");
      end else begin
        bus.rd <= fq.pop_front();
      end
    end
    bus.empty <= (fq.size() == 0);
  end

  typedef struct {
    logic       rdy;
    logic       re;
    logic       ov;
    logic       chk_d;
    logic [3:0] d;
    logic [3:0] cnt;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n, input logic [3:0] words [$]);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    fq.delete();
    foreach (words[i]) fq.push_back(words[i]);
    repeat (n - 1) @(negedge clk);
    #1;
    chk("rst_re", int'(bus.re), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // First vector is sampled on the negedge where reset was released.
  task automatic run_vecs(input string tag, input vec_t vs [$]);
    foreach (vs[i]) begin
      if (i > 0) @(negedge clk);
      bus.out_ready = vs[i].rdy;
      #1;
      chk($sformatf("%s_c%0d_re", tag, i), int'(bus.re), int'(vs[i].re));
      chk($sformatf("%s_c%0d_valid", tag, i), int'(bus.out_valid), int'(vs[i].ov));
      chk($sformatf("%s_c%0d_count", tag, i), int'(count), int'(vs[i].cnt));
      if (vs[i].chk_d)
        chk($sformatf("%s_c%0d_data", tag, i), int'(bus.out_data), int'(vs[i].d));
    end
  endtask

  initial begin
    vec_t stream_v [$];
    vec_t bp_v [$];
    logic [3:0] w [$];
    int delivered;
    int expw;
    logic prev_hold;
    logic [3:0] prev_d;
    logic [3:0] nxt;

    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.rd = '0;
    bus.empty = 1'b1;

    // rdy, re, ov, chk_d, d, cnt
    stream_v = '{
      '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'd0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'd1},
      '{1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 4'd2},
      '{1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 4'd3},
      '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'd4}
    };
    bp_v = '{
      '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 4'h8, 4'd0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 4'd0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 4'd0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 4'd0},
      '{1'b1, 1'b0, 1'b1, 1'b1, 4'h8, 4'd0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 4'h9, 4'd1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 4'd2},
      '{1'b1, 1'b1, 1'b1, 1'b1, 4'hB, 4'd3},
      '{1'b1, 1'b1, 1'b1, 1'b1, 4'hC, 4'd4},
      '{1'b1, 1'b1, 1'b1, 1'b1, 4'hD, 4'd5},
      '{1'b1, 1'b0, 1'b1, 1'b1, 4'hE, 4'd6},
      '{1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 4'd7},
      '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'd8}
    };

    w = '{4'h0, 4'h1, 4'h2, 4'h3};
    do_reset(10, w);
    run_vecs("stream", stream_v);

    w = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    do_reset(3, w);
    run_vecs("bp", bp_v);

    // Throughput: FIFO topped up every cycle, consumer always ready.
    w = '{4'h0, 4'h1};
    do_reset(3, w);
    nxt = 4'h2;
    delivered = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      fq.push_back(nxt);
      nxt = nxt + 4'h1;
      bus.out_ready = 1'b1;
      #1;
      if (c >= 2) chk($sformatf("tp_c%0d_valid", c), int'(bus.out_valid), 1);
      if (bus.out_valid) begin
        chk($sformatf("tp_w%0d_data", delivered), int'(bus.out_data), delivered % 16);
        delivered++;
      end
    end
    chk("tp_words_ge_18", int'(delivered >= 18), 1);
    @(negedge clk);
    #1;
    chk("tp_count", int'(count), delivered % 16);

    // Random ready toggling: order, hold-while-stalled, no loss or duplication.
    w.delete();
    for (int i = 0; i < 16; i++) w.push_back(4'(i));
    do_reset(3, w);
    expw = 0;
    prev_hold = 1'b0;
    prev_d = '0;
    for (int c = 0; c < 400 && expw < 16; c++) begin
      if (c > 0) @(negedge clk);
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_hold) begin
        chk($sformatf("rnd_c%0d_hold_valid", c), int'(bus.out_valid), 1);
        chk($sformatf("rnd_c%0d_hold_data", c), int'(bus.out_data), int'(prev_d));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("rnd_w%0d_data", expw), int'(bus.out_data), expw);
        expw++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_d = bus.out_data;
    end
    chk("rnd_delivered", expw, 16);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("rnd_count_wrapped", int'(count), 0);
    chk("rnd_drained_valid", int'(bus.out_valid), 0);

    // Reset while occ=2 and one read in flight; the in-flight word (3) must be lost.
    w = '{4'h1, 4'h2, 4'h3, 4'h4};
    do_reset(3, w);
    #1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_re", int'(bus.re), 0);
    chk("mid_rst_valid_before", int'(bus.out_valid), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_after_valid", int'(bus.out_valid), 0);
    chk("mid_after_count", int'(count), 0);
    chk("mid_after_re", int'(bus.re), 1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("mid_c5_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    #1;
    chk("mid_c6_valid", int'(bus.out_valid), 1);
    chk("mid_c6_data", int'(bus.out_data), 4);
    @(negedge clk);
    #1;
    chk("mid_c7_valid", int'(bus.out_valid), 0);
    chk("mid_c7_count", int'(count), 1);

    // Counter wrap with CW=4: 17 deliveries leave count at 1.
    w.delete();
    for (int i = 0; i < 17; i++) w.push_back(4'(i));
    do_reset(3, w);
    delivered = 0;
    for (int c = 0; c < 80 && delivered < 17; c++) begin
      if (c > 0) @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) delivered++;
    end
    chk("wrap_delivered", delivered, 17);
    @(negedge clk);
    #1;
    chk("wrap_count", int'(count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
